// File: rtl/sparhixcel_pkg.sv
// rtl/sparhixcel_pkg.sv - shared saturation limits and accumulator FSM encoding
package sparhixcel_pkg;

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Limits are returned 64 bits wide; callers keep the low w bits.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/psum_accumulator_if.sv
// rtl/psum_accumulator_if.sv - term input / window sum output handshake bundle
interface psum_accumulator_if #(
    parameter int W = 16
);
    logic         clear_i;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [W-1:0] data_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [W-1:0] psum_o;
    logic         ovf_o;

    modport master (
        output clear_i, in_valid_i, data_i, out_ready_i,
        input  in_ready_o, out_valid_o, psum_o, ovf_o
    );

    modport slave (
        input  clear_i, in_valid_i, data_i, out_ready_i,
        output in_ready_o, out_valid_o, psum_o, ovf_o
    );
endinterface

// File: rtl/adder_without_en.sv
// rtl/adder_without_en.sv - combinational unsigned adder with carry out
module adder_without_en #(
    parameter int W = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] s_o,
    output logic         c_o
);
    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i};
endmodule

// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - saturating fixed-point window accumulator, ACC_LEN terms per output
module psum_accumulator
    import sparhixcel_pkg::*;
#(
    parameter int I_WIDTH = 8,
    parameter int F_WIDTH = 8,
    parameter int ACC_LEN = 9
) (
    input  logic              clk,
    input  logic              rst,
    psum_accumulator_if.slave bus
);
    localparam int W  = I_WIDTH + F_WIDTH;
    localparam int CW = $clog2(ACC_LEN + 1);
    localparam logic [63:0]   SAT_MAX_L = sat_max(W);
    localparam logic [63:0]   SAT_MIN_L = sat_min(W);
    localparam logic [W-1:0]  SAT_MAX   = SAT_MAX_L[W-1:0];
    localparam logic [W-1:0]  SAT_MIN   = SAT_MIN_L[W-1:0];
    localparam logic [CW-1:0] CNT_LAST  = CW'(ACC_LEN - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  acc;
    logic          ovf;
    logic          in_ready_r;
    logic          out_valid_r;

    logic [W-1:0]  sum;
    logic          carry_unused;
    logic          ovf_now;
    logic [W-1:0]  sat_sum;
    logic          first_term;
    logic          last_term;

    adder_without_en #(.W(W)) u_add (
        .a_i (acc),
        .b_i (bus.data_i),
        .s_o (sum),
        .c_o (carry_unused)
    );

    // Two's-complement overflow: like-signed operands producing an opposite-signed sum.
    assign ovf_now    = (acc[W-1] == bus.data_i[W-1]) && (sum[W-1] != acc[W-1]);
    assign sat_sum    = ovf_now ? (acc[W-1] ? SAT_MIN : SAT_MAX) : sum;
    assign first_term = (cnt == '0);
    assign last_term  = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_ACC;
            cnt         <= '0;
            acc         <= '0;
            ovf         <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (bus.clear_i) begin
                        cnt <= '0;
                        acc <= '0;
                        ovf <= 1'b0;
                    end else if (bus.in_valid_i) begin
                        acc <= first_term ? bus.data_i : sat_sum;
                        ovf <= first_term ? 1'b0 : (ovf | ovf_now);
                        if (last_term) begin
                            state       <= ST_HOLD;
                            in_ready_r  <= 1'b0;
                            out_valid_r <= 1'b1;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    // Window result is frozen here; clear_i and new terms are ignored.
                    if (bus.out_ready_i) begin
                        state       <= ST_ACC;
                        cnt         <= '0;
                        ovf         <= 1'b0;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                    end
                end
                default: state <= ST_ACC;
            endcase
        end
    end

    assign bus.in_ready_o  = in_ready_r;
    assign bus.out_valid_o = out_valid_r;
    assign bus.psum_o      = acc;
    assign bus.ovf_o       = ovf;
endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - directed checks of psum_accumulator at ACC_LEN 4, 3, 2 and 1
module tb_psum_accumulator;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] data = '0;
    logic        out_ready = 1'b0;
    int          n_assert = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    psum_accumulator_if #(.W(16)) if4 ();
    psum_accumulator_if #(.W(16)) if3 ();
    psum_accumulator_if #(.W(16)) if2 ();
    psum_accumulator_if #(.W(16)) if1 ();

    assign if4.clear_i = clear; assign if4.in_valid_i = in_valid; assign if4.data_i = data; assign if4.out_ready_i = out_ready;
    assign if3.clear_i = clear; assign if3.in_valid_i = in_valid; assign if3.data_i = data; assign if3.out_ready_i = out_ready;
    assign if2.clear_i = clear; assign if2.in_valid_i = in_valid; assign if2.data_i = data; assign if2.out_ready_i = out_ready;
    assign if1.clear_i = clear; assign if1.in_valid_i = in_valid; assign if1.data_i = data; assign if1.out_ready_i = out_ready;

    psum_accumulator #(.I_WIDTH(8), .F_WIDTH(8), .ACC_LEN(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    psum_accumulator #(.I_WIDTH(8), .F_WIDTH(8), .ACC_LEN(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));
    psum_accumulator #(.I_WIDTH(8), .F_WIDTH(8), .ACC_LEN(2)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));
    psum_accumulator #(.I_WIDTH(8), .F_WIDTH(8), .ACC_LEN(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] d);
        in_valid = 1'b1;
        data     = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        #1;
        do_reset();
        chk("rst_in_ready", if4.in_ready_o, 16'h1);
        chk("rst_out_valid", if4.out_valid_o, 16'h0);
        chk("rst_psum", if4.psum_o, 16'h0);
        chk("rst_ovf", if4.ovf_o, 16'h0);

        // Mixed-sign terms back-to-back, window of 4
        push(16'h0100); push(16'h0200); push(16'hFF00);
        chk("basic_not_valid_at_3", if4.out_valid_o, 16'h0);
        push(16'h0080);
        chk("basic_valid", if4.out_valid_o, 16'h1);
        chk("basic_psum", if4.psum_o, 16'h0280);
        chk("basic_ovf", if4.ovf_o, 16'h0);
        chk("basic_in_ready_hold", if4.in_ready_o, 16'h0);
        release_out();
        chk("basic_released_valid", if4.out_valid_o, 16'h0);
        chk("basic_released_ready", if4.in_ready_o, 16'h1);

        // Positive saturation then recovery, window of 3
        do_reset();
        push(16'h7000); push(16'h2000);
        chk("possat_mid", if3.psum_o, 16'h7FFF);
        push(16'hF000);
        chk("possat_valid", if3.out_valid_o, 16'h1);
        chk("possat_psum", if3.psum_o, 16'h6FFF);
        chk("possat_ovf", if3.ovf_o, 16'h1);

        // Negative saturation, window of 2
        do_reset();
        push(16'h8800); push(16'h8800);
        chk("negsat_valid", if2.out_valid_o, 16'h1);
        chk("negsat_psum", if2.psum_o, 16'h8000);
        chk("negsat_ovf", if2.ovf_o, 16'h1);

        // Pass-through, window of 1
        do_reset();
        push(16'h1234);
        chk("len1_valid", if1.out_valid_o, 16'h1);
        chk("len1_psum", if1.psum_o, 16'h1234);
        chk("len1_ovf", if1.ovf_o, 16'h0);
        release_out();
        push(16'hFFFF);
        chk("len1_psum2", if1.psum_o, 16'hFFFF);
        chk("len1_ovf2", if1.ovf_o, 16'h0);

        // Backpressure in HOLD with input traffic, then a clean next window
        do_reset();
        for (int i = 0; i < 4; i++) push(16'h0100);
        in_valid = 1'b1;
        data     = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_psum_stable", if4.psum_o, 16'h0400);
            chk("bp_in_ready", if4.in_ready_o, 16'h0);
            chk("bp_valid", if4.out_valid_o, 16'h1);
        end
        in_valid = 1'b0;
        clear    = 1'b1;
        tick();
        clear    = 1'b0;
        chk("hold_clear_valid", if4.out_valid_o, 16'h1);
        chk("hold_clear_psum", if4.psum_o, 16'h0400);
        release_out();
        for (int i = 0; i < 4; i++) push(16'h0010);
        chk("bp_next_psum", if4.psum_o, 16'h0040);
        chk("bp_next_ovf", if4.ovf_o, 16'h0);
        release_out();

        // clear_i mid-window drops the same-cycle term
        push(16'h0100); push(16'h0100);
        clear    = 1'b1;
        in_valid = 1'b1;
        data     = 16'h0700;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clear_psum", if4.psum_o, 16'h0000);
        chk("clear_ready", if4.in_ready_o, 16'h1);
        chk("clear_valid", if4.out_valid_o, 16'h0);
        for (int i = 0; i < 3; i++) push(16'h0100);
        chk("clear_count_restart", if4.out_valid_o, 16'h0);
        push(16'h0100);
        chk("clear_next_psum", if4.psum_o, 16'h0400);
        release_out();

        // rst mid-window beats a same-cycle term
        push(16'h0100); push(16'h0100);
        rst      = 1'b1;
        in_valid = 1'b1;
        data     = 16'h0300;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rstmid_psum", if4.psum_o, 16'h0000);
        chk("rstmid_ovf", if4.ovf_o, 16'h0);
        chk("rstmid_valid", if4.out_valid_o, 16'h0);
        chk("rstmid_ready", if4.in_ready_o, 16'h1);
        for (int i = 0; i < 4; i++) push(16'h0200);
        chk("rstmid_next_psum", if4.psum_o, 16'h0800);
        chk("rstmid_next_valid", if4.out_valid_o, 16'h1);

        // rst in HOLD beats out_ready_i
        rst       = 1'b1;
        out_ready = 1'b1;
        tick();
        rst       = 1'b0;
        out_ready = 1'b0;
        chk("rsthold_valid", if4.out_valid_o, 16'h0);
        chk("rsthold_psum", if4.psum_o, 16'h0000);

        // Gapped input: only accepted terms advance the window
        for (int k = 0; k < 4; k++) begin
            push(16'h0100);
            if (k < 3) begin
                chk("gap_not_valid", if4.out_valid_o, 16'h0);
                repeat (3) tick();
                chk("gap_psum_held", if4.psum_o, 16'((k + 1) * 16'h0100));
            end
        end
        chk("gap_valid", if4.out_valid_o, 16'h1);
        chk("gap_psum", if4.psum_o, 16'h0400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/psum_accumulator.md
PSUM_ACCUMULATOR -- requirements
Module: psum_accumulator

Interface
REQ-001 Parameters SHALL be: I_WIDTH, default 8, integer bits; F_WIDTH, default 8, fraction bits; ACC_LEN, default 9, terms per output (legal range 1..255).
REQ-002 W SHALL denote I_WIDTH+F_WIDTH; all data SHALL be signed two's-complement fixed point (QI_WIDTH.F_WIDTH).
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 clear_i  in  1  aborts the current window and discards its partial sum.
REQ-007 in_valid_i  in  1  data_i valid.
REQ-008 in_ready_o  out  1  block accepts data_i.
REQ-009 data_i  in  W  signed term to accumulate.
REQ-010 out_valid_o  out  1  psum_o valid.
REQ-011 out_ready_i  in  1  downstream accepts psum_o.
REQ-012 psum_o  out  W  saturated window sum.
REQ-013 ovf_o  out  1  at least one saturation occurred in this window.

Function
REQ-014 A term SHALL be accepted when in_valid_i and in_ready_o are both high on a rising edge.
REQ-015 The FSM SHALL have two states: ACC (in_ready_o=1, out_valid_o=0) and HOLD (in_ready_o=0, out_valid_o=1).
REQ-016 In ACC, the first accepted term of a window SHALL load acc directly; each later term SHALL update acc to sat(acc+data_i).
REQ-017 Signed overflow SHALL be detected as: operand signs equal and sum sign different; positive overflow SHALL give 0x7FF..F and negative overflow 0x800..0.
REQ-018 Accumulation SHALL continue from the saturated value; saturation is not sticky on the data, only on ovf_o.
REQ-019 A term counter SHALL count 0..ACC_LEN-1; acceptance at count ACC_LEN-1 SHALL transition ACC->HOLD.
REQ-020 psum_o and ovf_o SHALL be valid on the cycle after the last term is accepted (latency 1).
REQ-021 psum_o and ovf_o SHALL remain stable in HOLD until out_valid_o and out_ready_i are both high.
REQ-022 That handshake SHALL transition HOLD->ACC, clear the counter, and clear ovf.
REQ-023 In HOLD, in_valid_i SHALL be ignored.
REQ-024 Gaps in in_valid_i SHALL not alter acc or the counter.
REQ-025 ACC_LEN=1 SHALL pass each term through with ovf_o=0.
REQ-026 clear_i in ACC SHALL zero the counter, acc and ovf; any term presented in the same cycle SHALL be dropped.
REQ-027 clear_i in HOLD SHALL have no effect.
REQ-028 in_ready_o SHALL depend only on state, with no combinational path from any input.

Reset
REQ-029 On rst: state=ACC, counter=0, acc=0, psum_o=0, ovf_o=0, out_valid_o=0, in_ready_o=1.
REQ-030 rst SHALL take priority over clear_i and over both handshakes, including when asserted mid-window or in HOLD.

Structure
REQ-031 Shared package sparhixcel_pkg SHALL hold the SAT_MAX/SAT_MIN constant functions of W and the FSM state encoding.
REQ-032 The counter width SHALL be $clog2(ACC_LEN+1), computed locally.
REQ-033 The sum SHALL be formed by one instance of the existing combinational adder_without_en (a_i=acc, b_i=data_i); overflow SHALL be derived from operand and sum signs, not from c_o.

Verification (W=16, Q8.8)
REQ-034 ACC_LEN=4, terms 0x0100, 0x0200, 0xFF00, 0x0080 back-to-back -> psum_o=0x0280, ovf_o=0, out_valid_o high the cycle after the 4th accept.
REQ-035 ACC_LEN=3, terms 0x7000, 0x2000, 0xF000 -> saturates to 0x7FFF, final psum_o=0x6FFF, ovf_o=1.
REQ-036 ACC_LEN=2, terms 0x8800, 0x8800 -> psum_o=0x8000, ovf_o=1.
REQ-037 out_ready_i held low for 5 cycles in HOLD while in_valid_i=1 with data 0x1234 -> psum_o unchanged, in_ready_o=0, next window unaffected.
REQ-038 ACC_LEN=4: clear_i after 2 terms, then 4 terms of 0x0100 -> psum_o=0x0400; repeat with rst after 2 terms -> all outputs 0, next window correct.
REQ-039 ACC_LEN=4, terms 0x0100 with 3-cycle gaps between accepts -> psum_o=0x0400, counter advances only on accepts.
